mult_cdb_buffer: RTL
====================

Name: mult_cdb_buffer

Overview:
- Completion buffer directly downstream of the two pipelined multipliers (lanes C and D).
- Captures every done result (product, pr_idx, mt_idx, rob_idx, NPC) into a small FIFO, then presents one entry at a time to the CDB arbiter with a req/grant handshake.
- Multipliers cannot stall once started, so the block gives issue logic an early-stall signal that guarantees in-flight results always have space.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- STALL_THRESH, 4, mult_stall asserts when free entries <= STALL_THRESH; covers both lanes' in-flight ops.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  branch-mispredict squash; synchronous, clears the buffer.
- doneC_in  in  1  lane C result valid this cycle.
- productC_in  in  64  lane C product.
- pr_idxC_in  in  6  lane C physical register index.
- mt_idxC_in  in  5  lane C map-table index.
- rob_idxC_in  in  5  lane C ROB index.
- NPCC_in  in  64  lane C NPC.
- doneD_in, productD_in, pr_idxD_in, mt_idxD_in, rob_idxD_in, NPCD_in  in  1/64/6/5/5/64  lane D equivalents.
- cdb_grant  in  1  arbiter accepts the head entry this cycle.
- cdb_req  out  1  head entry valid.
- cdb_value  out  64  head product.
- cdb_pr_idx  out  6  head pr_idx.
- cdb_mt_idx  out  5  head mt_idx.
- cdb_rob_idx  out  5  head rob_idx.
- cdb_NPC  out  64  head NPC.
- count  out  log2(DEPTH)+1  occupied entries.
- mult_stall  out  1  issue must not start a new MULQ.
- overflow_err  out  1  sticky: a result was dropped.

Behaviour:
- Reset (reset=0, async):
  - head/tail/count = 0, overflow_err = 0.
  - cdb_req = 0; all cdb_* data = 0 (pr_idx/mt_idx/rob_idx = 0).
  - mult_stall = 0.
  - Storage contents are don't-care.
- Registered FIFO; no bypass.
  - A result with done=1 at edge N is written at edge N.
  - cdb_req can rise in cycle N+1 at the earliest.
- cdb_* outputs are driven combinationally from the head entry. When count==0: cdb_req=0 and all cdb_* data forced to 0.
- Pop: cdb_req && cdb_grant at an edge removes the head. A grant while cdb_req=0 is ignored.
- Push order: when doneC_in and doneD_in are both 1 in the same cycle, C is written at tail and D at tail+1.
- Push/pop in the same cycle:
  - The pop frees its slot first, so a full buffer accepts one push when it also pops.
  - count_next = count + pushes - pop.
- Overflow:
  - Any push that does not fit after the pop is dropped and sets overflow_err (sticky until reset).
  - If only one of two pushes fits, C is kept and D is dropped.
  - Existing entries are never corrupted.
- Pointers wrap modulo DEPTH. count distinguishes full (count==DEPTH) from empty.
- mult_stall = (DEPTH - count) <= STALL_THRESH. It is combinational from registered count.
- flush=1 at an edge:
  - count, head and tail go to 0.
  - Pushes and pop in that cycle are discarded; a grant on a flush cycle does not count.
  - cdb_req=0 the next cycle.
  - overflow_err is not cleared by flush.
- Order guarantee: CDB output order equals arrival order (C before D on ties).
- No state machine beyond the FIFO pointers. Occupancy states are empty / partial / stall-zone / full, and all transitions follow from count_next.

Test Plan:
- Reset then idle:
  - reset low mid-cycle -> all outputs zero immediately.
  - After release with no done: cdb_req=0, count=0, mult_stall=0 (DEPTH=8, THRESH=4).
- Single result, grant held high:
  - Push C (product=0x2A, pr_idx=7, rob_idx=3) -> cdb_req=1 next cycle with cdb_value=0x2A, cdb_pr_idx=7, cdb_rob_idx=3.
  - Popped on that edge; cdb_req=0 after.
- Dual push, tie order, grant low:
  - C(product=1) and D(product=2) in the same cycle -> count=2.
  - Raise grant -> cdb_value 1 then 2 on consecutive cycles.
- Fill with grant low:
  - 4 pushes -> count=4, mult_stall=1.
  - Fill to 8 -> count=8.
  - Push C+D while granting -> C accepted, D dropped, overflow_err=1, count stays 8.
- Wrap-around:
  - Stream 20 single pushes with grant at 50% -> output sequence equals input sequence, no loss, overflow_err=0.
- Flush:
  - With count=5, assert flush together with doneC and grant -> count=0 and cdb_req=0 next cycle.
  - overflow_err unchanged.

Source files
------------

// File: rtl/mult_cdb_buffer.sv
// Completion FIFO between the two pipelined multipliers (lanes C/D) and the CDB arbiter.
// Latency: a result written at edge N is presented on cdb_* from cycle N+1. There is no bypass path.
// Backpressure: the head is held until cdb_grant. Because the multipliers cannot stall, mult_stall is raised early.
//
// Ports:
//   clock, reset (async, active-low), flush (sync squash)
//   doneX_in/productX_in/pr_idxX_in/mt_idxX_in/rob_idxX_in/NPCX_in for lanes X = C, D
//   cdb_grant in; cdb_req/cdb_value/cdb_pr_idx/cdb_mt_idx/cdb_rob_idx/cdb_NPC out (head entry)
//   count (occupancy), mult_stall (issue hold-off), overflow_err (sticky drop flag)
module mult_cdb_buffer #(
  parameter int DEPTH        = 8,
  parameter int STALL_THRESH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     doneC_in,
  input  logic [63:0]              productC_in,
  input  logic [5:0]               pr_idxC_in,
  input  logic [4:0]               mt_idxC_in,
  input  logic [4:0]               rob_idxC_in,
  input  logic [63:0]              NPCC_in,
  input  logic                     doneD_in,
  input  logic [63:0]              productD_in,
  input  logic [5:0]               pr_idxD_in,
  input  logic [4:0]               mt_idxD_in,
  input  logic [4:0]               rob_idxD_in,
  input  logic [63:0]              NPCD_in,
  input  logic                     cdb_grant,
  output logic                     cdb_req,
  output logic [63:0]              cdb_value,
  output logic [5:0]               cdb_pr_idx,
  output logic [4:0]               cdb_mt_idx,
  output logic [4:0]               cdb_rob_idx,
  output logic [63:0]              cdb_NPC,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mult_stall,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(STALL_THRESH);

  logic [63:0] prod_mem [DEPTH];
  logic [5:0]  pr_mem   [DEPTH];
  logic [4:0]  mt_mem   [DEPTH];
  logic [4:0]  rob_mem  [DEPTH];
  logic [63:0] npc_mem  [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, d_idx;
  logic [CW-1:0] count_q, count_d, space;
  logic          ovf_q, ovf_d;
  logic          empty, pop, push_c, push_d;

  assign empty = (count_q == '0);

  always_comb begin
    pop    = !empty && cdb_grant;
    // Free slots once this cycle's pop has retired the head.
    space  = DEPTH_C - count_q + CW'(pop);
    // C takes the first free slot, so on a single-slot shortfall D is the one dropped.
    push_c = doneC_in && (space != '0);
    push_d = doneD_in && (push_c ? (space >= CW'(2)) : (space != '0));
    d_idx  = tail_q + AW'(push_c);

    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push_c) + AW'(push_d);
    count_d = count_q + CW'(push_c) + CW'(push_d) - CW'(pop);
    ovf_d   = ovf_q | (doneC_in & ~push_c) | (doneD_in & ~push_d);

    // A squash discards everything in flight this cycle, drops included; the error flag survives.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // The payload needs no reset: it is only visible while count_q is nonzero.
  always_ff @(posedge clock) begin
    if (!flush) begin
      if (push_c) begin
        prod_mem[tail_q] <= productC_in;
        pr_mem[tail_q]   <= pr_idxC_in;
        mt_mem[tail_q]   <= mt_idxC_in;
        rob_mem[tail_q]  <= rob_idxC_in;
        npc_mem[tail_q]  <= NPCC_in;
      end
      if (push_d) begin
        prod_mem[d_idx] <= productD_in;
        pr_mem[d_idx]   <= pr_idxD_in;
        mt_mem[d_idx]   <= mt_idxD_in;
        rob_mem[d_idx]  <= rob_idxD_in;
        npc_mem[d_idx]  <= NPCD_in;
      end
    end
  end

  assign cdb_req      = !empty;
  assign cdb_value    = empty ? '0 : prod_mem[head_q];
  assign cdb_pr_idx   = empty ? '0 : pr_mem[head_q];
  assign cdb_mt_idx   = empty ? '0 : mt_mem[head_q];
  assign cdb_rob_idx  = empty ? '0 : rob_mem[head_q];
  assign cdb_NPC      = empty ? '0 : npc_mem[head_q];
  assign count        = count_q;
  assign mult_stall   = (DEPTH_C - count_q) <= THRESH_C;
  assign overflow_err = ovf_q;

endmodule
